// File: rtl/core_tlb_ctrl_pkg.sv
// Shared types and constants for the TLB writer: entry layout, update
// broadcast bundle, op encodings and INVTLB op codes.
package core_tlb_ctrl_pkg;

    localparam int TLB_ENTRY_NUM = 32;
    localparam int IDX_W         = $clog2(TLB_ENTRY_NUM);

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G1         = 5'd2;
    localparam logic [4:0] INV_G0         = 5'd3;
    localparam logic [4:0] INV_G0_ASID    = 5'd4;
    localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA      = 5'd6;

    typedef enum logic {
        MODE_SRCH = 1'b0,
        MODE_INV  = 1'b1
    } match_mode_e;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_value_t;

    typedef struct packed {
        tlb_key_t         key;
        tlb_value_t [1:0] value;
    } tlb_entry_t;

    typedef struct packed {
        logic [TLB_ENTRY_NUM-1:0] tlb_we;
        tlb_entry_t               tlb_w_entry;
    } tlb_update_req_t;

endpackage

// File: rtl/tlb_ctrl_match.sv
// Match rule for one shadow entry, used both for TLBSRCH and for each
// INVTLB sweep step.
module tlb_ctrl_match
    import core_tlb_ctrl_pkg::*;
(
    input  tlb_key_t    key,
    input  logic [18:0] vppn,
    input  logic [9:0]  asid,
    input  logic [4:0]  invop,
    input  match_mode_e mode,
    output logic        match
);

    logic asid_eq;
    logic va_eq;

    // Evaluate the rule; invalid entries never match, so INVTLB only
    // broadcasts writes for entries that actually change.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        asid_eq = (key.asid == asid);
        va_eq   = (key.ps == 6'd22) ? (key.vppn[18:9] == vppn[18:9]) : (key.vppn == vppn);
        match   = 1'b0;
        if (mode == MODE_SRCH) begin
            match = key.e && (key.g || asid_eq) && va_eq;
        end else begin
            case (invop)
                INV_ALL0, INV_ALL1: match = key.e;
                INV_G1:             match = key.e && key.g;
                INV_G0:             match = key.e && !key.g;
                INV_G0_ASID:        match = key.e && !key.g && asid_eq;
                INV_G0_ASID_VA:     match = key.e && !key.g && asid_eq && va_eq;
                INV_GA_VA:          match = key.e && (key.g || asid_eq) && va_eq;
                default:            match = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/core_tlb_ctrl.sv
// TLB writer: owns the shadow entry table, executes SRCH/RD/WR/FILL/INV
// and broadcasts one-hot entry writes to all translators.
module core_tlb_ctrl
    import core_tlb_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 ready_o,
    input  logic [2:0]           req_op_i,
    input  tlb_entry_t           w_entry_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [18:0]          srch_vppn_i,
    input  logic [9:0]           asid_i,
    input  logic [4:0]           invop_i,
    input  logic [18:0]          inv_vppn_i,
    output logic                 done_o,
    output logic                 srch_found_o,
    output logic [IDX_W-1:0]     srch_index_o,
    output tlb_entry_t           rd_entry_o,
    output tlb_update_req_t      tlb_update_req_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_INV_SWEEP, S_DONE} state_e;

    state_e                   state_q, state_d;
    tlb_entry_t               shadow [TLB_ENTRY_NUM];
    tlb_entry_t               view   [TLB_ENTRY_NUM];
    logic [TLB_ENTRY_NUM-1:0] shadow_e;
    logic [TLB_ENTRY_NUM-1:0] srch_match;
    logic [IDX_W-1:0]         srch_idx;
    logic [IDX_W-1:0]         fill_cnt, idx_q, sweep_k, wr_idx;
    logic [2:0]               op_q;
    tlb_entry_t               entry_q, wr_entry, rd_next;
    logic [9:0]               asid_q;
    logic [4:0]               invop_q;
    logic [18:0]              inv_vppn_q;
    logic                     accept, inv_match, wr_en;

    assign accept = req_valid_i && (state_q == S_IDLE);

    // Readable view of the table: the resettable valid vector qualifies e.
    always_comb begin
        for (int k = 0; k < TLB_ENTRY_NUM; k++) begin
            view[k]       = shadow[k];
            view[k].key.e = shadow[k].key.e & shadow_e[k];
        end
    end

    for (genvar k = 0; k < TLB_ENTRY_NUM; k++) begin : g_srch
        tlb_ctrl_match u_match (
            .key   (view[k].key),
            .vppn  (srch_vppn_i),
            .asid  (asid_i),
            .invop (5'd0),
            .mode  (MODE_SRCH),
            .match (srch_match[k])
        );
    end

    tlb_ctrl_match u_inv_match (
        .key   (view[sweep_k].key),
        .vppn  (inv_vppn_q),
        .asid  (asid_q),
        .invop (invop_q),
        .mode  (MODE_INV),
        .match (inv_match)
    );

    // Search index is the OR of all hit indices; RD of an invalid entry reads as zero.
    always_comb begin
        srch_idx = '0;
        for (int k = 0; k < TLB_ENTRY_NUM; k++) begin
            if (srch_match[k]) srch_idx = srch_idx | IDX_W'(k);
        end
        rd_next = view[idx_i].key.e ? view[idx_i] : '0;
    end

    // Capture SRCH/RD results at accept so they appear in EXEC and hold afterwards.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srch_found_o <= 1'b0;
            srch_index_o <= '0;
            rd_entry_o   <= '0;
        end else if (accept) begin
            if (req_op_i == OP_SRCH) begin
                srch_found_o <= |srch_match;
                srch_index_o <= srch_idx;
            end
            if (req_op_i == OP_RD) rd_entry_o <= rd_next;
        end
    end

    // Latch request operands on accept; FILL takes the fill counter as its index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            idx_q      <= '0;
            entry_q    <= '0;
            asid_q     <= '0;
            invop_q    <= '0;
            inv_vppn_q <= '0;
        end else if (accept) begin
            op_q       <= req_op_i;
            idx_q      <= (req_op_i == OP_FILL) ? fill_cnt : idx_i;
            entry_q    <= w_entry_i;
            asid_q     <= asid_i;
            invop_q    <= invop_i;
            inv_vppn_q <= inv_vppn_i;
        end
    end

    // Free-running fill counter and sweep index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            sweep_k  <= '0;
        end else begin
            fill_cnt <= fill_cnt + 1'b1;
            sweep_k  <= (state_q == S_INV_SWEEP) ? sweep_k + 1'b1 : '0;
        end
    end

    // Select the single entry write for this cycle, if any.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        wr_entry = entry_q;
        if (state_q == S_EXEC && (op_q == OP_WR || op_q == OP_FILL)) begin
            wr_en = 1'b1;
        end else if (state_q == S_INV_SWEEP && inv_match) begin
            wr_en          = 1'b1;
            wr_idx         = sweep_k;
            wr_entry       = view[sweep_k];
            wr_entry.key.e = 1'b0;
        end
    end

    // Shadow data payload, written on the same edge the translators sample.
    // NOTE: the entry array is not reset; only the valid vector below is.
    always_ff @(posedge clk) begin
        if (wr_en) shadow[wr_idx] <= wr_entry;
    end

    // Resettable valid bits so every entry reads invalid after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_e <= '0;
        else if (wr_en) shadow_e[wr_idx] <= wr_entry.key.e;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, handshake, completion pulse and update broadcast.
    always_comb begin
        state_d          = state_q;
        ready_o          = 1'b0;
        done_o           = 1'b0;
        tlb_update_req_o = '0;
        tlb_update_req_o.tlb_we[wr_idx] = wr_en;
        tlb_update_req_o.tlb_w_entry    = wr_en ? wr_entry : '0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_valid_i) state_d = (req_op_i == OP_INV) ? S_INV_SWEEP : S_EXEC;
            end
            S_EXEC: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_INV_SWEEP: begin
                if (sweep_k == IDX_W'(TLB_ENTRY_NUM - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_tlb_ctrl.sv
// Directed self-checking bench for core_tlb_ctrl.
module tb_core_tlb_ctrl;
    import core_tlb_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            ready;
    logic [2:0]      req_op = '0;
    tlb_entry_t      w_entry = '0;
    logic [4:0]      idx = '0;
    logic [18:0]     srch_vppn = '0;
    logic [9:0]      asid = '0;
    logic [4:0]      invop = '0;
    logic [18:0]     inv_vppn = '0;
    logic            done;
    logic            srch_found;
    logic [4:0]      srch_index;
    tlb_entry_t      rd_entry;
    tlb_update_req_t upd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [4:0] m_fill;
    int acc_cyc;
    logic [4:0] acc_fill;
    logic [31:0] log_we[$];
    tlb_entry_t  log_ent[$];
    int          log_cyc[$];

    core_tlb_ctrl dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .ready_o(ready),
        .req_op_i(req_op), .w_entry_i(w_entry), .idx_i(idx),
        .srch_vppn_i(srch_vppn), .asid_i(asid), .invop_i(invop),
        .inv_vppn_i(inv_vppn), .done_o(done), .srch_found_o(srch_found),
        .srch_index_o(srch_index), .rd_entry_o(rd_entry),
        .tlb_update_req_o(upd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference fill counter.
    always @(posedge clk or posedge rst) begin
        if (rst) m_fill <= '0;
        else     m_fill <= m_fill + 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every broadcast write, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && (|upd.tlb_we)) begin
            log_we.push_back(upd.tlb_we);
            log_ent.push_back(upd.tlb_w_entry);
            log_cyc.push_back(cyc);
            check("we_onehot", $countones(upd.tlb_we), 1);
        end
    end

    function automatic tlb_entry_t mk(logic [18:0] v, logic [5:0] ps, logic g, logic [9:0] a, logic e);
        tlb_entry_t t;
        t = '0;
        t.key.vppn = v;  t.key.ps = ps; t.key.g = g; t.key.asid = a; t.key.e = e;
        t.value[0].ppn = {1'b0, v};  t.value[0].v = 1'b1; t.value[0].mat = 2'd1;
        t.value[1].ppn = {1'b1, ~v}; t.value[1].d = 1'b1; t.value[1].plv = 2'd3;
        return t;
    endfunction

    function automatic logic [31:0] first_we();
        return (log_we.size() > 0) ? log_we[0] : 32'd0;
    endfunction

    // Issue one op and wait (bounded) for done; lat counts cycles after accept.
    task automatic run_op(input logic [2:0] op, input logic [4:0] i, input tlb_entry_t ent,
                          input logic [18:0] sv, input logic [9:0] a, input logic [4:0] io,
                          input logic [18:0] iv, output int lat);
        @(negedge clk);
        log_we.delete(); log_ent.delete(); log_cyc.delete();
        req_op = op; idx = i; w_entry = ent; srch_vppn = sv; asid = a; invop = io; inv_vppn = iv;
        req_valid = 1'b1;
        acc_fill = m_fill;
        @(posedge clk);
        #1 req_valid = 1'b0;
        acc_cyc = cyc;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            #1 lat++;
            if (done) break;
        end
    endtask

    tlb_entry_t e3, e9, e1, e2, e3b, e12, ef, tmp;
    int lat, f1, f2, bad;

    initial begin
        e3  = mk(19'h12345, 6'd12, 1'b0, 10'd7, 1'b1);
        e9  = mk(19'h7FE00, 6'd22, 1'b1, 10'h3FF, 1'b1);
        ef  = mk(19'h55555, 6'd12, 1'b1, 10'd0, 1'b1);
        e1  = mk(19'h00100, 6'd12, 1'b1, 10'd0, 1'b1);
        e2  = mk(19'h00200, 6'd12, 1'b0, 10'd4, 1'b1);
        e3b = mk(19'h00300, 6'd12, 1'b0, 10'd5, 1'b1);
        e12 = mk(19'h01200, 6'd12, 1'b0, 10'd9, 1'b1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_found", srch_found, 1'b0);
        check("rst_rd", rd_entry, '0);
        check("rst_we", upd.tlb_we, 32'd0);

        run_op(OP_RD, 5'd5, '0, '0, '0, '0, '0, lat);
        check("rd5_lat", lat, 1);
        check("rd5_entry", rd_entry, '0);
        check("rd5_nowe", log_we.size(), 0);

        run_op(OP_WR, 5'd3, e3, '0, '0, '0, '0, lat);
        check("wr3_lat", lat, 1);
        check("wr3_wecnt", log_we.size(), 1);
        check("wr3_we", first_we(), 32'h8);
        check("wr3_ent", (log_ent.size() > 0) ? log_ent[0] : '0, e3);

        run_op(OP_SRCH, '0, '0, 19'h12345, 10'd7, '0, '0, lat);
        check("srch_a7_lat", lat, 1);
        check("srch_a7_found", srch_found, 1'b1);
        check("srch_a7_idx", srch_index, 5'd3);
        run_op(OP_SRCH, '0, '0, 19'h12345, 10'd8, '0, '0, lat);
        check("srch_a8_found", srch_found, 1'b0);

        run_op(OP_RD, 5'd3, '0, '0, '0, '0, '0, lat);
        check("rd3_entry", rd_entry, e3);

        run_op(OP_WR, 5'd9, e9, '0, '0, '0, '0, lat);
        run_op(OP_SRCH, '0, '0, 19'h7FFFF, 10'h123, '0, '0, lat);
        check("srch_ps22_found", srch_found, 1'b1);
        check("srch_ps22_idx", srch_index, 5'd9);

        run_op(3'd7, '0, e9, '0, '0, '0, '0, lat);
        check("undef_lat", lat, 1);
        check("undef_nowe", log_we.size(), 0);
        check("undef_hold", srch_index, 5'd9);

        run_op(OP_FILL, 5'd0, ef, '0, '0, '0, '0, lat);
        f1 = acc_fill;
        check("fill1_wecnt", log_we.size(), 1);
        check("fill1_we", first_we(), 32'd1 << f1);
        repeat (9) @(posedge clk);
        run_op(OP_FILL, 5'd0, ef, '0, '0, '0, '0, lat);
        f2 = acc_fill;
        check("fill2_wecnt", log_we.size(), 1);
        check("fill2_we", first_we(), 32'd1 << f2);

        run_op(OP_WR, 5'd1, e1, '0, '0, '0, '0, lat);
        run_op(OP_WR, 5'd2, e2, '0, '0, '0, '0, lat);
        run_op(OP_WR, 5'd3, e3b, '0, '0, '0, '0, lat);
        run_op(OP_INV, '0, '0, '0, 10'd4, 5'd4, '0, lat);
        check("inv4_lat", lat, 33);
        check("inv4_wecnt", log_we.size(), 1);
        check("inv4_we", first_we(), 32'h4);
        check("inv4_k", (log_cyc.size() > 0) ? log_cyc[0] - acc_cyc : -1, 2);
        tmp = e2;
        tmp.key.e = 1'b0;
        check("inv4_ent", (log_ent.size() > 0) ? log_ent[0] : '0, tmp);
        run_op(OP_RD, 5'd2, '0, '0, '0, '0, '0, lat);
        check("inv4_rd2", rd_entry, '0);
        run_op(OP_RD, 5'd1, '0, '0, '0, '0, '0, lat);
        check("inv4_rd1", rd_entry, e1);
        run_op(OP_RD, 5'd3, '0, '0, '0, '0, '0, lat);
        check("inv4_rd3", rd_entry, e3b);

        run_op(OP_WR, 5'd31, e12, '0, '0, '0, '0, lat);
        run_op(OP_RD, 5'd31, '0, '0, '0, '0, '0, lat);
        check("rd31_entry", rd_entry, e12);
        run_op(OP_WR, 5'd12, e12, '0, '0, '0, '0, lat);

        // Reset in the middle of an invalidate-all sweep.
        @(negedge clk);
        req_op = OP_INV; invop = 5'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1 check("sweep_busy", ready, 1'b0);
        rst = 1'b1;
        #1 log_we.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_nowe", log_we.size(), 0);
        check("abort_ready", ready, 1'b1);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            run_op(OP_RD, 5'(k), '0, '0, '0, '0, '0, lat);
            if (rd_entry.key.e !== 1'b0 || lat != 1) bad++;
        end
        check("abort_all_e0", bad, 0);
        run_op(OP_SRCH, '0, '0, 19'h01200, 10'd9, '0, '0, lat);
        check("abort_srch12", srch_found, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
